// File: rtl/verificador_speed.sv
// Clocked self-checking harness for a full adder: sweeps all 3-bit vectors, compares
// reference and synthesized adder outputs with each other and with a golden sum.
module verificador_speed #(
  parameter int N_PASADAS = 1,
  parameter int ERR_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inicio,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             s_ref,
  input  logic             carry_ref,
  input  logic             s_dut,
  input  logic             carry_dut,
  output logic             ocupado,
  output logic             listo,
  output logic             pasa,
  output logic [ERR_W-1:0] n_errores,
  output logic [2:0]       primer_error,
  output logic             error_valido,
  output logic             error_modelo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [7:0]       LAST_PASS = 8'(N_PASADAS - 1);

  state_t           r_state;
  logic [2:0]       r_vec;
  logic [7:0]       r_pasada;
  logic [ERR_W-1:0] r_n_errores;
  logic [2:0]       r_primer_error;
  logic             r_error_valido;
  logic             r_error_modelo;
  logic             r_ocupado;
  logic             r_listo;
  logic             r_pasa;

  logic             w_s_exp;
  logic             w_carry_exp;
  logic             w_model_err;
  logic             w_dut_err;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;

  assign w_s_exp     = ^r_vec;
  assign w_carry_exp = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
  assign w_model_err = {s_ref, carry_ref} != {w_s_exp, w_carry_exp};
  assign w_dut_err   = {s_ref, carry_ref} != {s_dut, carry_dut};
  assign w_mismatch  = w_model_err | w_dut_err;
  // Count saturates so a long faulty run never wraps back to a passing value.
  assign w_err_next  = (w_mismatch && (r_n_errores != ERR_MAX)) ?
                       r_n_errores + ERR_W'(1) : r_n_errores;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_vec          <= 3'd0;
      r_pasada       <= 8'd0;
      r_n_errores    <= '0;
      r_primer_error <= 3'd0;
      r_error_valido <= 1'b0;
      r_error_modelo <= 1'b0;
      r_ocupado      <= 1'b0;
      r_listo        <= 1'b0;
      r_pasa         <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (inicio) begin
            r_state        <= RUN;
            r_vec          <= 3'd0;
            r_pasada       <= 8'd0;
            r_n_errores    <= '0;
            r_error_valido <= 1'b0;
            r_error_modelo <= 1'b0;
            r_ocupado      <= 1'b1;
            r_listo        <= 1'b0;
            r_pasa         <= 1'b0;
          end
        end
        RUN: begin
          r_n_errores <= w_err_next;
          if (w_mismatch && !r_error_valido) begin
            r_primer_error <= r_vec;
            r_error_valido <= 1'b1;
          end
          if (w_model_err) r_error_modelo <= 1'b1;
          r_vec <= r_vec + 3'd1;
          // The last vector is checked on the same edge that enters DONE.
          if (r_vec == 3'd7) begin
            if (r_pasada == LAST_PASS) begin
              r_state   <= DONE;
              r_ocupado <= 1'b0;
              r_listo   <= 1'b1;
              r_pasa    <= (w_err_next == '0);
            end else begin
              r_pasada <= r_pasada + 8'd1;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_vec     <= 3'd0;
          r_ocupado <= 1'b0;
          r_listo   <= 1'b0;
        end
      endcase
    end
  end

  assign {a, b, c}    = r_vec;
  assign ocupado      = r_ocupado;
  assign listo        = r_listo;
  assign pasa         = r_pasa;
  assign n_errores    = r_n_errores;
  assign primer_error = r_primer_error;
  assign error_valido = r_error_valido;
  assign error_modelo = r_error_modelo;

endmodule

// File: tb/tb_verificador_speed.sv
// Bench for verificador_speed: two instances (1 pass/4-bit count, 2 passes/2-bit count)
// driven by emulated adders with injectable faults, checked against a run-position model.
module tb_verificador_speed;

  logic clk, reset, inicio;
  logic a0, b0, c0, s_ref0, carry_ref0, s_dut0, carry_dut0;
  logic ocup0, listo0, pasa0, ev0, em0;
  logic [3:0] nerr0;
  logic [2:0] pe0;
  logic a1, b1, c1, s_ref1, carry_ref1, s_dut1, carry_dut1;
  logic ocup1, listo1, pasa1, ev1, em1;
  logic [1:0] nerr1;
  logic [2:0] pe1;

  // Fault masks per vector, bit order {s, carry}, XORed onto the correct adder output.
  logic [1:0] rx [8];
  logic [1:0] dx [8];

  int checks = 0;
  int failures = 0;

  verificador_speed u0 (
    .clk(clk), .reset(reset), .inicio(inicio), .a(a0), .b(b0), .c(c0),
    .s_ref(s_ref0), .carry_ref(carry_ref0), .s_dut(s_dut0), .carry_dut(carry_dut0),
    .ocupado(ocup0), .listo(listo0), .pasa(pasa0), .n_errores(nerr0),
    .primer_error(pe0), .error_valido(ev0), .error_modelo(em0));

  verificador_speed #(.N_PASADAS(2), .ERR_W(2)) u1 (
    .clk(clk), .reset(reset), .inicio(inicio), .a(a1), .b(b1), .c(c1),
    .s_ref(s_ref1), .carry_ref(carry_ref1), .s_dut(s_dut1), .carry_dut(carry_dut1),
    .ocupado(ocup1), .listo(listo1), .pasa(pasa1), .n_errores(nerr1),
    .primer_error(pe1), .error_valido(ev1), .error_modelo(em1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] gold(input logic [2:0] v);
    return {v[2] ^ v[1] ^ v[0], (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])};
  endfunction

  assign {s_ref0, carry_ref0} = gold({a0, b0, c0}) ^ rx[{a0, b0, c0}];
  assign {s_dut0, carry_dut0} = gold({a0, b0, c0}) ^ dx[{a0, b0, c0}];
  assign {s_ref1, carry_ref1} = gold({a1, b1, c1}) ^ rx[{a1, b1, c1}];
  assign {s_dut1, carry_dut1} = gold({a1, b1, c1}) ^ dx[{a1, b1, c1}];

  // Model: a run is just a position k in 0..8*N-1; vector = k mod 8.
  typedef struct {
    bit       run;
    int       k;
    int       cnt;
    bit       ev;
    bit [2:0] pe;
    bit       em;
    bit       done;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t step(input mdl_t s, input int np, input bit ini);
    mdl_t r;
    int v;
    r = s;
    if (!r.run) begin
      if (ini) begin
        r.run = 1; r.k = 0; r.cnt = 0; r.ev = 0; r.em = 0; r.done = 0;
      end
    end else begin
      v = r.k % 8;
      if (rx[v] != 2'b00 || rx[v] != dx[v]) begin
        r.cnt++;
        if (!r.ev) begin r.ev = 1; r.pe = 3'(v); end
      end
      if (rx[v] != 2'b00) r.em = 1;
      r.k++;
      if (r.k == 8 * np) begin r.run = 0; r.done = 1; end
    end
    return r;
  endfunction

  function automatic mdl_t zero_m();
    mdl_t r;
    r.run = 0; r.k = 0; r.cnt = 0; r.ev = 0; r.pe = 0; r.em = 0; r.done = 0;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m[0] <= zero_m();
      m[1] <= zero_m();
    end else begin
      m[0] <= step(m[0], 1, inicio);
      m[1] <= step(m[1], 2, inicio);
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[u%0d] actual=%0d required=%0d t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [2:0] v, input logic oc, input logic li,
                          input logic pa, input int ne, input logic [2:0] pe,
                          input logic ev, input logic em, input int mx);
    int exp_n;
    exp_n = (m[i].cnt > mx) ? mx : m[i].cnt;
    chk("vector", i, 32'(v), m[i].run ? 32'(m[i].k % 8) : 32'd0);
    chk("ocupado", i, 32'(oc), 32'(m[i].run));
    chk("listo", i, 32'(li), 32'(m[i].done));
    chk("pasa", i, 32'(pa), 32'(m[i].done && m[i].cnt == 0));
    chk("n_errores", i, 32'(ne), 32'(exp_n));
    chk("primer_error", i, 32'(pe), 32'(m[i].pe));
    chk("error_valido", i, 32'(ev), 32'(m[i].ev));
    chk("error_modelo", i, 32'(em), 32'(m[i].em));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, {a0, b0, c0}, ocup0, listo0, pasa0, int'(nerr0), pe0, ev0, em0, 15);
    cmp_inst(1, {a1, b1, c1}, ocup1, listo1, pasa1, int'(nerr1), pe1, ev1, em1, 3);
  end

  task automatic set_mode(input int md);
    for (int v = 0; v < 8; v++) begin
      rx[v] = 2'b00;
      dx[v] = 2'b00;
      case (md)
        1: if (v == 5) dx[v] = 2'b10;
        2: rx[v] = {1'b0, gold(3'(v)) & 2'b01};
        3: dx[v] = 2'b10;
        4: begin
          if ($urandom_range(3) == 0) rx[v] = 2'($urandom);
          if ($urandom_range(3) == 0) dx[v] = 2'($urandom);
        end
        default: ;
      endcase
    end
  endtask

  // One-cycle start pulse; waits for both instances to finish, counting busy cycles.
  task automatic do_run(output int busy0, output int busy1);
    bit ok;
    ok = 0;
    busy0 = 0;
    busy1 = 0;
    @(negedge clk) inicio = 1'b1;
    @(negedge clk) inicio = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (ocup0) busy0++;
      if (ocup1) busy1++;
      if (listo0 && listo1) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("run_timeout", 0, 32'(ok), 32'd1);
  endtask

  int bz0, bz1;
  bit found;

  initial begin
    reset = 1'b0;
    inicio = 1'b0;
    set_mode(0);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ocupado", 0, 32'(ocup0), 32'd0);
    chk("reset_nerr", 0, 32'(nerr0), 32'd0);
    #1 reset = 1'b0;

    // Clean run
    do_run(bz0, bz1);
    chk("clean_busy", 0, 32'(bz0), 32'd8);
    chk("clean_busy", 1, 32'(bz1), 32'd16);
    chk("clean_pasa", 0, 32'(pasa0), 32'd1);
    chk("clean_nerr", 0, 32'(nerr0), 32'd0);
    chk("clean_ev", 0, 32'(ev0), 32'd0);

    // Saturation: s_dut always inverted
    set_mode(3);
    do_run(bz0, bz1);
    chk("sat_nerr", 1, 32'(nerr1), 32'd3);
    chk("sat_pasa", 1, 32'(pasa1), 32'd0);
    chk("sat_busy", 1, 32'(bz1), 32'd16);
    chk("sat_nerr", 0, 32'(nerr0), 32'd8);

    // Single fault at 101
    set_mode(1);
    do_run(bz0, bz1);
    chk("single_nerr", 0, 32'(nerr0), 32'd1);
    chk("single_pe", 0, 32'(pe0), 32'd5);
    chk("single_pasa", 0, 32'(pasa0), 32'd0);
    chk("single_em", 0, 32'(em0), 32'd0);
    chk("single_nerr", 1, 32'(nerr1), 32'd2);

    // Broken reference: carry_ref stuck at 0
    set_mode(2);
    do_run(bz0, bz1);
    chk("brokenref_nerr", 0, 32'(nerr0), 32'd4);
    chk("brokenref_pe", 0, 32'(pe0), 32'd3);
    chk("brokenref_em", 0, 32'(em0), 32'd1);
    chk("brokenref_nerr", 1, 32'(nerr1), 32'd3);

    // Reset mid-run at vector 100 (011 already counted by then)
    @(negedge clk) inicio = 1'b1;
    @(negedge clk) inicio = 1'b0;
    found = 0;
    for (int t = 0; t < 20; t++) begin
      if ({a0, b0, c0} == 3'b100) begin found = 1; break; end
      @(negedge clk);
    end
    chk("reach_100", 0, 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_vec", 0, 32'({a0, b0, c0}), 32'd0);
    chk("async_ocupado", 0, 32'(ocup0), 32'd0);
    chk("async_nerr", 0, 32'(nerr0), 32'd0);
    chk("async_pe", 0, 32'(pe0), 32'd0);
    chk("async_ev", 0, 32'(ev0), 32'd0);
    chk("async_em", 0, 32'(em0), 32'd0);
    @(negedge clk) #1 reset = 1'b0;
    set_mode(0);
    do_run(bz0, bz1);
    chk("post_reset_busy", 0, 32'(bz0), 32'd8);
    chk("post_reset_pasa", 0, 32'(pasa0), 32'd1);

    // inicio held high: no mid-run restart; DONE restarts and clears on that edge
    set_mode(1);
    bz0 = 0;
    found = 0;
    @(negedge clk) inicio = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (listo0) begin found = 1; break; end
      if (ocup0) bz0++;
    end
    chk("held_listo", 0, 32'(found), 32'd1);
    chk("held_busy", 0, 32'(bz0), 32'd8);
    chk("held_nerr_before", 0, 32'(nerr0), 32'd1);
    @(posedge clk) #1;
    chk("restart_listo", 0, 32'(listo0), 32'd0);
    chk("restart_ocupado", 0, 32'(ocup0), 32'd1);
    chk("restart_nerr", 0, 32'(nerr0), 32'd0);
    chk("restart_ev", 0, 32'(ev0), 32'd0);
    @(negedge clk) inicio = 1'b0;
    repeat (20) @(negedge clk);

    // Randomized phase
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      inicio = ($urandom_range(3) == 0);
      if ($urandom_range(49) == 0) set_mode($urandom_range(4));
      if ($urandom_range(399) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk) #1 reset = 1'b0;
      end
    end
    inicio = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
